// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   mduState_t  : sequencer states (idle, Booth multiply, restoring divide,
//                 sign fix-up, completion)
//   MDU_ITER    : number of iteration steps per operation
//   MDU_CNT_W   : width of the iteration counter (must hold MDU_ITER)
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_IDLE,
    MDU_MULT,
    MDU_DIV,
    MDU_FIX,
    MDU_DONE
  } mduState_t;

  localparam int MDU_ITER  = 32;
  localparam int MDU_CNT_W = 6;

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// The top module feeds this back through its registers once per cycle.
//   remIn    : partial remainder so far (always < divisor)
//   quoIn    : dividend bits still to be consumed (MSB first), with the
//              quotient bits produced so far filling in from the LSB
//   divisor  : unsigned divisor magnitude
//   remOut   : next partial remainder
//   quoOut   : quoIn shifted left by one with the new quotient bit appended
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] quoOut
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           quoBit;

  // Shift the next dividend bit into the remainder and try subtracting the
  // divisor. One extra bit keeps the trial result's sign visible: a set MSB
  // means the subtraction went negative, so the shifted value is restored.
  always_comb begin
    shifted = {remIn, quoIn[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    quoBit  = ~trial[WIDTH];
    if (quoBit) begin
      remOut = trial[WIDTH-1:0];
    end else begin
      remOut = shifted[WIDTH-1:0];
    end
    quoOut = {quoIn[WIDTH-2:0], quoBit};
  end

endmodule

// File: rtl/mult_div_seq.sv
// Multicycle signed multiply/divide sequencer owning the HI/LO result path.
// A start pulse in IDLE latches the operands; multiply runs radix-2 Booth,
// divide runs restoring division on magnitudes followed by a sign fix-up.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   start_mult, start_div : one-cycle start pulses (multiply has priority)
//   op_a, op_b            : multiplicand/dividend and multiplier/divisor
//   busy                  : high from the cycle after the start through DONE
//   done                  : one-cycle completion pulse
//   div_zero              : divisor was zero; held until the next start
//   hi, lo                : product high/low, or remainder/quotient
module mult_div_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mduState_t            state;
  logic [MDU_CNT_W-1:0] count;
  // accReg is the Booth accumulator during multiply and the partial
  // remainder during divide. It carries one guard bit so that subtracting a
  // multiplicand of -2^(WIDTH-1) cannot overflow the accumulator.
  logic [WIDTH:0]       accReg;
  logic [WIDTH-1:0]     qReg;
  logic                 qPrev;
  logic [WIDTH-1:0]     operandM;
  logic                 signA;
  logic                 signB;

  logic [WIDTH:0]       mExt;
  logic [WIDTH:0]       boothSum;
  logic [WIDTH-1:0]     remNext;
  logic [WIDTH-1:0]     quoNext;

  function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // Booth recoding of the pair {Q[0], q-1}: 01 adds the multiplicand,
  // 10 subtracts it, 00/11 leave the accumulator alone.
  always_comb begin
    mExt = {operandM[WIDTH-1], operandM};
    case ({qReg[0], qPrev})
      2'b01:   boothSum = accReg + mExt;
      2'b10:   boothSum = accReg - mExt;
      default: boothSum = accReg;
    endcase
  end

  mdu_div_step #(.WIDTH(WIDTH)) divStep (
    .remIn   (accReg[WIDTH-1:0]),
    .quoIn   (qReg),
    .divisor (operandM),
    .remOut  (remNext),
    .quoOut  (quoNext)
  );

  // Sequencer. Both MULT and DIV spend one extra cycle after the last step
  // (count reaching MDU_ITER) so that done lands 33 cycles after a multiply
  // start and 34 after a divide start. A zero divisor enters DONE with done
  // still low and raises it on the following cycle, so that path also
  // reports one cycle after the start. hi/lo are written only at
  // completion, so partial results never appear on the outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= MDU_IDLE;
      count    <= '0;
      accReg   <= '0;
      qReg     <= '0;
      qPrev    <= 1'b0;
      operandM <= '0;
      signA    <= 1'b0;
      signB    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          done <= 1'b0;
          if (start_mult) begin
            operandM <= op_a;
            qReg     <= op_b;
            accReg   <= '0;
            qPrev    <= 1'b0;
            count    <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state    <= MDU_MULT;
          end else if (start_div) begin
            div_zero <= 1'b0;
            busy     <= 1'b1;
            count    <= '0;
            if (op_b == '0) begin
              state <= MDU_DONE;
            end else begin
              signA    <= op_a[WIDTH-1];
              signB    <= op_b[WIDTH-1];
              qReg     <= absVal(op_a);
              operandM <= absVal(op_b);
              accReg   <= '0;
              state    <= MDU_DIV;
            end
          end
        end

        MDU_MULT: begin
          if (count == MDU_CNT_W'(MDU_ITER)) begin
            hi    <= accReg[WIDTH-1:0];
            lo    <= qReg;
            done  <= 1'b1;
            state <= MDU_DONE;
          end else begin
            accReg <= {boothSum[WIDTH], boothSum[WIDTH:1]};
            qReg   <= {boothSum[0], qReg[WIDTH-1:1]};
            qPrev  <= qReg[0];
            count  <= count + MDU_CNT_W'(1);
          end
        end

        MDU_DIV: begin
          if (count == MDU_CNT_W'(MDU_ITER)) begin
            state <= MDU_FIX;
          end else begin
            accReg <= {1'b0, remNext};
            qReg   <= quoNext;
            count  <= count + MDU_CNT_W'(1);
          end
        end

        // Quotient is negative when the operand signs differ; the remainder
        // follows the dividend's sign (truncating division).
        MDU_FIX: begin
          lo    <= (signA ^ signB) ? -qReg : qReg;
          hi    <= signA ? -accReg[WIDTH-1:0] : accReg[WIDTH-1:0];
          done  <= 1'b1;
          state <= MDU_DONE;
        end

        MDU_DONE: begin
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= MDU_IDLE;
          end else begin
            done     <= 1'b1;
            div_zero <= 1'b1;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= MDU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: a table of directed vectors, a few
// hand-written multi-cycle sequences (arbitration, ignored start, reset
// during an operation) and randomized operations compared against a
// plain-arithmetic reference model.
module tb_mult_div_seq;

  localparam int WINDOW = 40;

  logic        clock;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] modelHi;
  logic [31:0] modelLo;

  typedef struct {
    logic        isDiv;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expZero;
    int          expLat;
  } vector_t;

  vector_t vecs[6];

  mult_div_seq #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Signed 32x32 arithmetic done directly on 64-bit integers.
  function automatic void refModel(input logic isDiv, input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic [31:0] pHi, input logic [31:0] pLo,
                                   output logic [31:0] eHi, output logic [31:0] eLo,
                                   output logic eZero, output int eLat);
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!isDiv) begin
      p     = sa * sb;
      eHi   = p[63:32];
      eLo   = p[31:0];
      eZero = 1'b0;
      eLat  = 33;
    end else if (b == 32'd0) begin
      eHi   = pHi;
      eLo   = pLo;
      eZero = 1'b1;
      eLat  = 1;
    end else begin
      q     = sa / sb;
      r     = sa % sb;
      eHi   = r[31:0];
      eLo   = q[31:0];
      eZero = 1'b0;
      eLat  = 34;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Issues one start pulse, then watches a fixed window of edges. Records
  // the edge of the first done, the number of done pulses, the results
  // seen with done, and whether busy stayed high up to and including done
  // and dropped right after it. injectAt > 0 pulses start_div mid-operation.
  task automatic applyStimulus(input logic m, input logic d,
                               input logic [31:0] a, input logic [31:0] b,
                               input int injectAt,
                               output int firstDone, output int doneCount,
                               output logic busyOk,
                               output logic [31:0] gotHi, output logic [31:0] gotLo,
                               output logic gotZero, output logic zeroHeld);
    @(negedge clock);
    start_mult = m;
    start_div  = d;
    op_a       = a;
    op_b       = b;
    @(posedge clock);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    busyOk     = busy;
    firstDone  = -1;
    doneCount  = 0;
    gotHi      = '0;
    gotLo      = '0;
    gotZero    = 1'b0;
    for (int e = 1; e <= WINDOW; e++) begin
      @(posedge clock);
      #1;
      start_div = 1'b0;
      if (e == injectAt) begin
        start_div = 1'b1;
        op_a      = 32'd100;
        op_b      = 32'd7;
      end
      if (done) begin
        doneCount++;
        if (firstDone < 0) begin
          firstDone = e;
          gotHi     = hi;
          gotLo     = lo;
          gotZero   = div_zero;
        end
      end
      if (firstDone < 0 || e == firstDone) begin
        if (!busy) busyOk = 1'b0;
      end else if (e == firstDone + 1) begin
        if (busy) busyOk = 1'b0;
      end
    end
    start_div = 1'b0;
    zeroHeld  = div_zero;
  endtask

  task automatic runAndCheck(input string name, input logic m, input logic d,
                             input logic [31:0] a, input logic [31:0] b,
                             input int injectAt,
                             input logic [31:0] eHi, input logic [31:0] eLo,
                             input logic eZero, input int eLat);
    int          firstDone;
    int          doneCount;
    logic        busyOk;
    logic [31:0] gotHi;
    logic [31:0] gotLo;
    logic        gotZero;
    logic        zeroHeld;
    applyStimulus(m, d, a, b, injectAt, firstDone, doneCount, busyOk,
                  gotHi, gotLo, gotZero, zeroHeld);
    checkOutput({name, " latency"}, 64'(firstDone), 64'(eLat));
    checkOutput({name, " doneCount"}, 64'(doneCount), 64'd1);
    checkOutput({name, " busy"}, 64'(busyOk), 64'd1);
    checkOutput({name, " hi"}, 64'(gotHi), 64'(eHi));
    checkOutput({name, " lo"}, 64'(gotLo), 64'(eLo));
    checkOutput({name, " divZero"}, 64'(gotZero), 64'(eZero));
    checkOutput({name, " divZeroHeld"}, 64'(zeroHeld), 64'(eZero));
    modelHi = eHi;
    modelLo = eLo;
  endtask

  initial begin
    logic [31:0] eHi;
    logic [31:0] eLo;
    logic        eZero;
    int          eLat;
    int          doneSeen;
    logic        isDiv;
    logic [31:0] a;
    logic [31:0] b;
    int          pick;

    vecs[0] = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    vecs[1] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    vecs[2] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    vecs[4] = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
    vecs[5] = '{1'b1, 32'd5,        32'd0,        32'd2,        32'd14,       1'b1, 1};

    reset      = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = '0;
    op_b       = '0;
    modelHi    = '0;
    modelLo    = '0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset divZero", 64'(div_zero), 64'd0);
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] directed vectors");
    foreach (vecs[i]) begin
      runAndCheck($sformatf("vec%0d", i), ~vecs[i].isDiv, vecs[i].isDiv,
                  vecs[i].a, vecs[i].b, 0, vecs[i].expHi, vecs[i].expLo,
                  vecs[i].expZero, vecs[i].expLat);
    end

    $display("[TB] simultaneous starts");
    runAndCheck("both starts", 1'b1, 1'b1, 32'd6, 32'd3, 0,
                32'd0, 32'd18, 1'b0, 33);

    $display("[TB] start_div during multiply");
    runAndCheck("ignored start", 1'b1, 1'b0, 32'hFFFFFFF0, 32'd9, 5,
                32'hFFFFFFFF, 32'hFFFFFF70, 1'b0, 33);

    $display("[TB] reset during divide");
    @(negedge clock);
    start_div = 1'b1;
    op_a      = 32'hFFFFFFF9;
    op_b      = 32'd2;
    @(posedge clock);
    #1;
    start_div = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("midReset busy", 64'(busy), 64'd0);
    checkOutput("midReset done", 64'(done), 64'd0);
    checkOutput("midReset divZero", 64'(div_zero), 64'd0);
    checkOutput("midReset hi", 64'(hi), 64'd0);
    checkOutput("midReset lo", 64'(lo), 64'd0);
    reset    = 1'b0;
    modelHi  = '0;
    modelLo  = '0;
    doneSeen = 0;
    for (int e = 0; e < WINDOW; e++) begin
      @(posedge clock);
      #1;
      if (done) doneSeen++;
    end
    checkOutput("midReset noDone", 64'(doneSeen), 64'd0);
    runAndCheck("after reset 100/7", 1'b0, 1'b1, 32'd100, 32'd7, 0,
                32'd2, 32'd14, 1'b0, 34);

    $display("[TB] randomized operations");
    for (int n = 0; n < 40; n++) begin
      pick  = $urandom_range(0, 9);
      isDiv = (pick >= 5);
      a     = $urandom;
      b     = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        b = 32'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      if (pick == 9) b = 32'd0;
      refModel(isDiv, a, b, modelHi, modelLo, eHi, eLo, eZero, eLat);
      runAndCheck($sformatf("rand%0d", n), ~isDiv, isDiv, a, b, 0,
                  eHi, eLo, eZero, eLat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
